// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl
// Sequencing controller and round-robin arbiter in front of the shared
// W-bit Booth multiply ALU. Two requesters compete for the ALU. The winner's
// opcode and operands are latched, then walked through the ALU start and
// operand-load handshake. The 2W-bit result is rebuilt from the high and low
// byte strobes and handed back to the winner. An ALU that stalls past
// TIMEOUT cycles is aborted.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-low reset
//   req0/req1         : request level, held until the matching done/err
//   op0/op1           : 2-bit opcode per requester
//   a0/a1, b0/b1      : operands M and Q per requester
//   done0/done1       : one-cycle result-valid pulse per requester
//   err0/err1         : one-cycle timeout-abort pulse per requester
//   res0/res1         : per-requester result register (2W bits)
//   busy              : high whenever the controller is not idle
//   alu_enable        : ALU enable, dropped for one cycle to force ALU idle
//   alu_start         : ALU start level
//   alu_op            : latched opcode to the ALU
//   alu_in            : operand bus to the ALU
//   alu_ready         : ALU idle indication
//   alu_out           : ALU result byte
//   alu_out_vld       : ALU byte strobe (high byte first, then low byte)

module alu_share_ctrl #(
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic           req1,
  input  logic [1:0]     op0,
  input  logic [1:0]     op1,
  input  logic [W-1:0]   a0,
  input  logic [W-1:0]   a1,
  input  logic [W-1:0]   b0,
  input  logic [W-1:0]   b1,
  output logic           done0,
  output logic           done1,
  output logic           err0,
  output logic           err1,
  output logic [2*W-1:0] res0,
  output logic [2*W-1:0] res1,
  output logic           busy,
  output logic           alu_enable,
  output logic           alu_start,
  output logic [1:0]     alu_op,
  output logic [W-1:0]   alu_in,
  input  logic           alu_ready,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_out_vld
);

  typedef enum logic [2:0] {
    IDLE, START, LOAD_A, LOAD_B, WAIT_HI, WAIT_LO, DONE, ABORT
  } state_t;

  // One extra bit so the counter never wraps while it overshoots LIMIT by
  // a cycle or two after a late high-byte strobe.
  localparam int            CW    = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic          last;
  logic          gnt;
  logic [1:0]    op_q;
  logic [W-1:0]  a_q, b_q, hi_q;
  logic [CW-1:0] cnt;
  logic          en_q;
  logic          grant_now;
  logic          grant_id;
  logic          timed_out;

  // Arbitration: a lone requester wins outright. On a tie the requester that
  // was not served last wins, which gives strict alternation under load.
  always_comb begin
    grant_id  = (req0 && req1) ? ~last : req1;
    grant_now = (state == IDLE) && alu_ready && (req0 || req1);
    timed_out = (cnt >= LIMIT);
  end

  // Next-state logic. A strobe in the final allowed cycle takes priority
  // over the timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_now) state_nx = START;
      START:   state_nx = LOAD_A;
      LOAD_A:  state_nx = LOAD_B;
      LOAD_B:  state_nx = WAIT_HI;
      WAIT_HI: begin
        if (alu_out_vld)    state_nx = WAIT_LO;
        else if (timed_out) state_nx = ABORT;
      end
      WAIT_LO: begin
        if (alu_out_vld)    state_nx = DONE;
        else if (timed_out) state_nx = ABORT;
      end
      DONE:    state_nx = IDLE;
      ABORT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state. The operand bus carries A through the start
  // fall so the ALU can load M, then carries B for one cycle for Q.
  always_comb begin
    busy       = (state != IDLE);
    alu_start  = (state == START);
    alu_enable = en_q && (state != ABORT);
    alu_op     = op_q;
    done0      = (state == DONE)  && !gnt;
    done1      = (state == DONE)  &&  gnt;
    err0       = (state == ABORT) && !gnt;
    err1       = (state == ABORT) &&  gnt;
    case (state)
      START, LOAD_A: alu_in = a_q;
      LOAD_B:        alu_in = b_q;
      default:       alu_in = '0;
    endcase
  end

  // State, latched request, timeout counter and result registers. The
  // result lands in res in the same edge that enters DONE. This makes res
  // valid together with the done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last  <= 1'b1;
      gnt   <= 1'b0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      cnt   <= '0;
      en_q  <= 1'b0;
      res0  <= '0;
      res1  <= '0;
    end else begin
      state <= state_nx;
      en_q  <= 1'b1;
      if (grant_now) begin
        gnt  <= grant_id;
        op_q <= grant_id ? op1 : op0;
        a_q  <= grant_id ? a1  : a0;
        b_q  <= grant_id ? b1  : b0;
        cnt  <= '0;
      end else if (state inside {START, LOAD_A, LOAD_B, WAIT_HI, WAIT_LO}) begin
        cnt <= cnt + CW'(1);
      end
      if (state == WAIT_HI && alu_out_vld) begin
        hi_q <= alu_out;
      end
      if (state == WAIT_LO && alu_out_vld) begin
        if (gnt) res1 <= {hi_q, alu_out};
        else     res0 <= {hi_q, alu_out};
      end
      if (state == DONE || state == ABORT) begin
        last <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl
// Self-checking bench for alu_share_ctrl. A behavioural ALU inside the bench
// signed-multiplies the operands it sees on the operand bus. A small
// reference model (round-robin owner, expected per-requester results) is
// computed from plain arithmetic on the requested operands.

module tb_alu_share_ctrl;

  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           req0 = 1'b0, req1 = 1'b0;
  logic [1:0]     op0 = '0, op1 = '0;
  logic [W-1:0]   a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic           done0, done1, err0, err1;
  logic [2*W-1:0] res0, res1;
  logic           busy, alu_enable, alu_start;
  logic [1:0]     alu_op;
  logic [W-1:0]   alu_in;
  logic           alu_ready = 1'b1;
  logic [W-1:0]   alu_out = '0;
  logic           alu_out_vld = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done0 = 0, n_done1 = 0, n_err0 = 0, n_err1 = 0;

  // Reference model state: who was served last and what each res should hold.
  bit          m_last = 1'b1;
  logic [15:0] m_res0 = '0, m_res1 = '0;

  alu_share_ctrl #(.W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .res0(res0), .res1(res1), .busy(busy),
    .alu_enable(alu_enable), .alu_start(alu_start), .alu_op(alu_op),
    .alu_in(alu_in), .alu_ready(alu_ready), .alu_out(alu_out),
    .alu_out_vld(alu_out_vld)
  );

  always #5 clk = ~clk;

  // Cycle counter and pulse counters, sampled on the rising edge, which
  // sees the values held during the cycle that just ended.
  always @(posedge clk) begin
    cyc++;
    if (done0 === 1'b1) n_done0++;
    if (done1 === 1'b1) n_done1++;
    if (err0  === 1'b1) n_err0++;
    if (err1  === 1'b1) n_err1++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [15:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return 16'(sa * sb);
  endfunction

  function automatic bit model_grant(input bit r0, input bit r1, input bit lastg);
    if (r0 && r1) return !lastg;
    return r1;
  endfunction

  // Behavioural ALU. It waits for the start pulse and records the operand
  // bus in START, LOAD_A and LOAD_B. It then returns the high and low product
  // bytes after the given idle gaps. A negative gap stops before that strobe.
  // On a full run it returns at the negative edge inside the DONE cycle.
  task automatic serve(input int hi_wait, input int lo_wait,
                       output logic [7:0] in_start, output logic [7:0] m,
                       output logic [7:0] q, output logic [7:0] in_wait,
                       output int n_start, output int start_cyc, output bit ok);
    logic [15:0] prod;
    ok = 1'b0;
    in_start = '0; m = '0; q = '0; in_wait = '0; n_start = 0; start_cyc = 0;
    for (int i = 0; i < 50 && alu_start !== 1'b1; i++) tick();
    if (alu_start !== 1'b1) return;
    start_cyc = cyc;
    in_start  = alu_in;
    n_start   = 1;
    tick(); m = alu_in;       n_start += int'(alu_start);
    tick(); q = alu_in;       n_start += int'(alu_start);
    tick(); in_wait = alu_in; n_start += int'(alu_start);
    ok   = 1'b1;
    prod = mul_ref(m, q);
    if (hi_wait < 0) return;
    repeat (hi_wait) tick();
    alu_out_vld = 1'b1; alu_out = prod[15:8];
    tick();
    alu_out_vld = 1'b0; alu_out = 8'($urandom);
    if (lo_wait < 0) return;
    repeat (lo_wait) tick();
    alu_out_vld = 1'b1; alu_out = prod[7:0];
    tick();
    alu_out_vld = 1'b0; alu_out = 8'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy actual=%0b expected=0", busy); end
    checks++; if ({done0, done1, err0, err1} !== 4'b0) begin errors++; $display("[TB] FAIL reset_pulses actual=%b expected=0000", {done0, done1, err0, err1}); end
    checks++; if (alu_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start actual=%0b expected=0", alu_start); end
    checks++; if ({alu_op, alu_in} !== 10'b0) begin errors++; $display("[TB] FAIL reset_op_in actual=%h expected=0", {alu_op, alu_in}); end
    checks++; if ({res0, res1} !== 32'b0) begin errors++; $display("[TB] FAIL reset_res actual=%h expected=0", {res0, res1}); end
    checks++; if (alu_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_enable actual=%0b expected=0", alu_enable); end
    rst = 1'b1;
    tick();
    checks++; if (alu_enable !== 1'b1) begin errors++; $display("[TB] FAIL enable_after_reset actual=%0b expected=1", alu_enable); end
    m_last = 1'b1; m_res0 = '0; m_res1 = '0;
  endtask

  task automatic test_single_multiply();
    logic [7:0] s, m, q, w;
    int ns, sc, d1;
    bit ok, g;
    d1 = n_done1;
    a0 = 8'd3; b0 = 8'hFE; op0 = 2'd2; req0 = 1'b1;
    g = model_grant(1'b1, 1'b0, m_last);
    serve(2, 1, s, m, q, w, ns, sc, ok);
    m_res0 = mul_ref(a0, b0);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_start actual=none expected=alu_start"); end
    checks++; if (done0 !== 1'b1) begin errors++; $display("[TB] FAIL single_done0 actual=%0b expected=1", done0); end
    checks++; if (res0 !== 16'hFFFA) begin errors++; $display("[TB] FAIL single_res0 actual=%h expected=fffa", res0); end
    checks++; if (alu_op !== op0) begin errors++; $display("[TB] FAIL single_op actual=%0d expected=%0d", alu_op, op0); end
    req0 = 1'b0;
    m_last = g;
    tick(); tick();
    checks++; if (n_done1 !== d1) begin errors++; $display("[TB] FAIL single_no_done1 actual=%0d expected=%0d", n_done1, d1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle actual=%0b expected=0", busy); end
  endtask

  task automatic test_operand_phasing();
    logic [7:0] s, m, q, w;
    int ns, sc;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'($urandom); req1 = 1'b1;
      serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), s, m, q, w, ns, sc, ok);
      m_res1 = mul_ref(a1, b1);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL phase_start actual=none expected=alu_start"); end
      checks++; if (s !== a1 || m !== a1) begin errors++; $display("[TB] FAIL phase_a actual=%h/%h expected=%h", s, m, a1); end
      checks++; if (q !== b1) begin errors++; $display("[TB] FAIL phase_b actual=%h expected=%h", q, b1); end
      checks++; if (w !== 8'h00) begin errors++; $display("[TB] FAIL phase_wait_bus actual=%h expected=00", w); end
      checks++; if (ns !== 1) begin errors++; $display("[TB] FAIL phase_start_len actual=%0d expected=1", ns); end
      checks++; if (done1 !== 1'b1 || res1 !== m_res1) begin errors++; $display("[TB] FAIL phase_result actual=%0b/%h expected=1/%h", done1, res1, m_res1); end
      checks++; if (alu_op !== op1) begin errors++; $display("[TB] FAIL phase_op actual=%0d expected=%0d", alu_op, op1); end
      req1 = 1'b0;
      m_last = 1'b1;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s, m, q, w;
    int ns, sc, prev_sc;
    bit ok, g;
    logic [15:0] exp_res;
    a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    prev_sc = 0;
    for (int i = 0; i < 6; i++) begin
      g = model_grant(1'b1, 1'b1, m_last);
      exp_res = g ? mul_ref(a1, b1) : mul_ref(a0, b0);
      serve(0, 0, s, m, q, w, ns, sc, ok);
      checks++; if (s !== (g ? a1 : a0)) begin errors++; $display("[TB] FAIL b2b_grant_operand iter=%0d actual=%h expected=%h", i, s, g ? a1 : a0); end
      checks++; if ({done1, done0} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL b2b_done iter=%0d actual=%b expected=%b", i, {done1, done0}, g ? 2'b10 : 2'b01); end
      checks++; if ((g ? res1 : res0) !== exp_res) begin errors++; $display("[TB] FAIL b2b_res iter=%0d actual=%h expected=%h", i, g ? res1 : res0, exp_res); end
      if (i > 0) begin
        checks++; if (sc - prev_sc < 7) begin errors++; $display("[TB] FAIL b2b_spacing iter=%0d actual=%0d expected>=7", i, sc - prev_sc); end
      end
      prev_sc = sc;
      if (g) m_res1 = exp_res; else m_res0 = exp_res;
      m_last = g;
      if (g) begin a1 = 8'($urandom); b1 = 8'($urandom); end
      else   begin a0 = 8'($urandom); b0 = 8'($urandom); end
    end
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    logic [7:0] s, m, q, w;
    int ns, sc, e0;
    bit ok, seen;
    e0 = n_err0;
    a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
    serve(-1, -1, s, m, q, w, ns, sc, ok);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (err0 === 1'b1) seen = 1'b1;
      else tick();
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL timeout_err actual=none expected=err0"); end
    checks++; if (cyc - sc !== TO) begin errors++; $display("[TB] FAIL timeout_delay actual=%0d expected=%0d", cyc - sc, TO); end
    checks++; if (alu_enable !== 1'b0 || err1 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("[TB] FAIL timeout_abort_outputs actual=en%0b e1%0b d0%0b expected=en0 e1 0 d0 0", alu_enable, err1, done0); end
    checks++; if (res0 !== m_res0) begin errors++; $display("[TB] FAIL timeout_res_kept actual=%h expected=%h", res0, m_res0); end
    req0 = 1'b0;
    m_last = 1'b0;
    tick();
    checks++; if (alu_enable !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_recover actual=en%0b busy%0b expected=en1 busy0", alu_enable, busy); end
    checks++; if (n_err0 !== e0 + 1) begin errors++; $display("[TB] FAIL timeout_err_count actual=%0d expected=%0d", n_err0, e0 + 1); end
    // Low byte lands in the last cycle before the abort would fire.
    a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
    serve(TO - 5, 0, s, m, q, w, ns, sc, ok);
    m_res0 = mul_ref(a0, b0);
    checks++; if (done0 !== 1'b1 || res0 !== m_res0) begin errors++; $display("[TB] FAIL timeout_edge_done actual=%0b/%h expected=1/%h", done0, res0, m_res0); end
    req0 = 1'b0;
    m_last = 1'b0;
    tick(); tick();
    checks++; if (n_err0 !== e0 + 1) begin errors++; $display("[TB] FAIL timeout_edge_no_err actual=%0d expected=%0d", n_err0, e0 + 1); end
  endtask

  task automatic test_alu_ready_low();
    logic [7:0] s, m, q, w;
    int ns, sc;
    bit ok;
    alu_ready = 1'b0;
    a1 = 8'($urandom); b1 = 8'($urandom); req1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (alu_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL ready_low_hold cycle=%0d actual=start%0b busy%0b expected=0/0", i, alu_start, busy); end
    end
    alu_ready = 1'b1;
    tick();
    checks++; if (alu_start !== 1'b1) begin errors++; $display("[TB] FAIL ready_rise_start actual=%0b expected=1", alu_start); end
    serve(0, 0, s, m, q, w, ns, sc, ok);
    m_res1 = mul_ref(a1, b1);
    checks++; if (done1 !== 1'b1 || res1 !== m_res1) begin errors++; $display("[TB] FAIL ready_result actual=%0b/%h expected=1/%h", done1, res1, m_res1); end
    req1 = 1'b0;
    m_last = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] s, m, q, w;
    int ns, sc, d0, e0;
    bit ok;
    a0 = 8'($urandom); b0 = 8'($urandom); req0 = 1'b1;
    serve(1, -1, s, m, q, w, ns, sc, ok);
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_before actual=%0b expected=1", busy); end
    d0 = n_done0; e0 = n_err0;
    rst = 1'b0; req0 = 1'b0;
    tick();
    m_last = 1'b1; m_res0 = '0; m_res1 = '0;
    checks++; if (busy !== 1'b0 || done0 !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle actual=busy%0b done%0b expected=0/0", busy, done0); end
    checks++; if (res0 !== m_res0 || res1 !== m_res1) begin errors++; $display("[TB] FAIL midrst_res_clear actual=%h/%h expected=0/0", res0, res1); end
    rst = 1'b1;
    tick();
    alu_out_vld = 1'b1; alu_out = 8'($urandom);
    tick();
    alu_out_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busy !== 1'b0 || alu_start !== 1'b0) begin errors++; $display("[TB] FAIL stray_vld cycle=%0d actual=busy%0b start%0b expected=0/0", i, busy, alu_start); end
    end
    checks++; if (n_done0 !== d0 || n_err0 !== e0) begin errors++; $display("[TB] FAIL midrst_no_pulse actual=%0d/%0d expected=%0d/%0d", n_done0, n_err0, d0, e0); end
    checks++; if (res0 !== m_res0) begin errors++; $display("[TB] FAIL midrst_res_after actual=%h expected=%h", res0, m_res0); end
  endtask

  initial begin
    tick();
    test_reset();
    test_single_multiply();
    test_operand_phasing();
    test_back_to_back();
    test_timeout();
    test_alu_ready_low();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
